// File: rtl/parity_slice_sequencer_if.sv
// Bus between the column-parity slice sequencer, the state/result memories and the parity unit.
// The slave modport is the sequencer side; master is the encoder/memory/unit side.
interface parity_slice_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int LANE_W = 25
);
  logic              start;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [LANE_W-1:0] rd_data;
  logic [LANE_W-1:0] unit_in1;
  logic [LANE_W-1:0] unit_in2;
  logic              unit_en;
  logic [LANE_W-1:0] unit_out;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANE_W-1:0] wr_data;

  modport slave (
    input  start, rd_data, unit_out,
    output busy, done, rd_en, rd_addr, unit_in1, unit_in2, unit_en,
           wr_en, wr_addr, wr_data
  );

  modport master (
    output start, rd_data, unit_out,
    input  busy, done, rd_en, rd_addr, unit_in1, unit_in2, unit_en,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/parity_slice_sequencer.sv
// Runs one column-parity pass: pairs slice z with slice z-1 (slice 0 with the last slice),
// feeds the pair to the parity unit and writes the unit result back at address z.
module parity_slice_sequencer #(
  parameter int NUM_SLICES = 64,
  parameter int ADDR_W     = 6,
  parameter int LANE_W     = 25,
  parameter int UNIT_LAT   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  parity_slice_sequencer_if.slave bus
);

  localparam int                CNT_W    = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SLICES - 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(UNIT_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_PREV  = 4'd1,
    S_CAP_PREV = 4'd2,
    S_RD_CUR   = 4'd3,
    S_LOAD     = 4'd4,
    S_ISSUE    = 4'd5,
    S_WAIT     = 4'd6,
    S_WRITE    = 4'd7,
    S_DONE     = 4'd8
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [LANE_W-1:0] prev_q;
  logic [LANE_W-1:0] cur_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              unit_en_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // Increment/decrement values used by the sequencer.
  always_comb begin
    idx_d = idx_q + ADDR_W'(1);
    cnt_d = cnt_q - CNT_ONE;
  end

  // Pass sequencer; every output strobe is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      unit_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            idx_q     <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= LAST_IDX;
            state_q   <= S_RD_PREV;
          end else begin
            busy_q    <= 1'b0;
            unit_en_q <= 1'b0;
          end
        end
        S_RD_PREV: begin
          state_q <= S_CAP_PREV;
        end
        S_CAP_PREV: begin
          prev_q    <= bus.rd_data;
          rd_en_q   <= 1'b1;
          rd_addr_q <= idx_q;
          state_q   <= S_RD_CUR;
        end
        S_RD_CUR: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          cur_q     <= bus.rd_data;
          unit_en_q <= 1'b1;
          state_q   <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_q <= CNT_INIT;
          if (UNIT_LAT > 1) begin
            state_q <= S_WAIT;
          end else begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            state_q   <= S_WRITE;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == CNT_ONE) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= idx_q;
            state_q   <= S_WRITE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WRITE: begin
          // The slice just processed becomes the z-1 partner of the next one.
          prev_q    <= cur_q;
          unit_en_q <= 1'b0;
          if (idx_q == LAST_IDX) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q     <= idx_d;
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_d;
            state_q   <= S_RD_CUR;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          unit_en_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.unit_in1 = cur_q;
  assign bus.unit_in2 = prev_q;
  assign bus.unit_en  = unit_en_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  // The unit result is only valid in the write cycle, so it is passed through rather than re-registered.
  assign bus.wr_data  = wr_en_q ? bus.unit_out : '0;

endmodule

// File: tb/tb_parity_slice_sequencer.sv
// Self-checking bench: memory and parity-unit models around two sequencers (unit latency 1 and 3),
// writes checked against mem[z] ^ mem[z-1 mod 64] computed directly from the memory image.
module tb_parity_slice_sequencer;
  localparam int N  = 64;
  localparam int AW = 6;
  localparam int LW = 25;
  localparam logic [LW-1:0] JUNK = 25'h15A5A5A;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  parity_slice_sequencer_if #(.ADDR_W(AW), .LANE_W(LW)) b1();
  parity_slice_sequencer_if #(.ADDR_W(AW), .LANE_W(LW)) b3();

  parity_slice_sequencer #(.NUM_SLICES(N), .ADDR_W(AW), .LANE_W(LW), .UNIT_LAT(1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  parity_slice_sequencer #(.NUM_SLICES(N), .ADDR_W(AW), .LANE_W(LW), .UNIT_LAT(3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic [LW-1:0] mem [N];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t0 = 0;
  int ucnt1 = 0;
  int ucnt3 = 0;

  // Synchronous-read memory and level-sensitive parity units with their latency.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    b1.rd_data <= b1.rd_en ? mem[b1.rd_addr] : JUNK;
    b3.rd_data <= b3.rd_en ? mem[b3.rd_addr] : JUNK;
    ucnt1   <= b1.unit_en ? ucnt1 + 1 : 0;
    ucnt3   <= b3.unit_en ? ucnt3 + 1 : 0;
  end
  assign b1.unit_out = (ucnt1 >= 1) ? (b1.unit_in1 ^ b1.unit_in2) : JUNK;
  assign b3.unit_out = (ucnt3 >= 3) ? (b3.unit_in1 ^ b3.unit_in2) : JUNK;

  int wa1[$]; logic [LW-1:0] wd1[$]; int wc1[$]; int dc1[$]; int ra1[$]; int rc1[$];
  logic [LW-1:0] iss_a[$]; logic [LW-1:0] iss_b[$];
  int wa3[$]; logic [LW-1:0] wd3[$]; int wc3[$]; int dc3[$];
  int ue3_cnt = 0;
  logic ue1_prev = 1'b0;

  // Monitors record every strobe with its cycle number.
  always @(negedge clk) begin
    if (b1.wr_en) begin wa1.push_back(int'(b1.wr_addr)); wd1.push_back(b1.wr_data); wc1.push_back(cyc); end
    if (b1.done) dc1.push_back(cyc);
    if (b1.rd_en) begin ra1.push_back(int'(b1.rd_addr)); rc1.push_back(cyc); end
    if (b1.unit_en && !ue1_prev) begin iss_a.push_back(b1.unit_in1); iss_b.push_back(b1.unit_in2); end
    ue1_prev <= b1.unit_en;
    if (b3.wr_en) begin wa3.push_back(int'(b3.wr_addr)); wd3.push_back(b3.wr_data); wc3.push_back(cyc); end
    if (b3.done) dc3.push_back(cyc);
    ue3_cnt <= ue3_cnt + (b3.unit_en ? 1 : 0);
  end

  function automatic logic [LW-1:0] exp_word(int z);
    return mem[z] ^ mem[(z + N - 1) % N];
  endfunction

  task automatic clear_mon();
    wa1.delete(); wd1.delete(); wc1.delete(); dc1.delete(); ra1.delete(); rc1.delete();
    iss_a.delete(); iss_b.delete(); wa3.delete(); wd3.delete(); wc3.delete(); dc3.delete();
  endtask

  task automatic fill_random();
    for (int z = 0; z < N; z++) mem[z] = LW'($urandom()) | 25'h1;
  endtask

  task automatic start1();
    @(negedge clk); b1.start = 1'b1; t0 = cyc;
    @(negedge clk); b1.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (b1.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", b1.busy); end
    checks++; if (b1.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", b1.done); end
    checks++; if (b1.rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%0b exp=0", b1.rd_en); end
    checks++; if (b1.unit_en !== 1'b0) begin errors++; $display("FAIL reset_unit_en got=%0b exp=0", b1.unit_en); end
    checks++; if (b1.wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%0b exp=0", b1.wr_en); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_pass();
    for (int z = 0; z < N; z++) mem[z] = LW'(z + 1);
    clear_mon();
    start1();
    repeat (300) @(negedge clk);
    checks++; if (wa1.size() != N) begin errors++; $display("FAIL full_wr_count got=%0d exp=%0d", wa1.size(), N); end
    if (wa1.size() == N) begin
      for (int z = 0; z < N; z++) begin
        checks++; if (wa1[z] != z) begin errors++; $display("FAIL full_wr_addr[%0d] got=%0d exp=%0d", z, wa1[z], z); end
        checks++; if (wd1[z] !== exp_word(z)) begin errors++; $display("FAIL full_wr_data[%0d] got=%0h exp=%0h", z, wd1[z], exp_word(z)); end
      end
      checks++; if (wd1[0] !== 25'd65) begin errors++; $display("FAIL full_wr_data0 got=%0d exp=65", wd1[0]); end
      checks++; if (wd1[1] !== 25'd3) begin errors++; $display("FAIL full_wr_data1 got=%0d exp=3", wd1[1]); end
      checks++; if (wc1[0] - t0 != 6) begin errors++; $display("FAIL full_first_write_cycle got=%0d exp=6", wc1[0] - t0); end
    end
    checks++; if (dc1.size() != 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", dc1.size()); end
    if (dc1.size() >= 1) begin
      checks++; if (dc1[0] - t0 != 259) begin errors++; $display("FAIL full_done_cycle got=%0d exp=259", dc1[0] - t0); end
    end
    checks++; if (ra1.size() != N + 1) begin errors++; $display("FAIL full_rd_count got=%0d exp=%0d", ra1.size(), N + 1); end
    if (ra1.size() == N + 1) begin
      for (int k = 0; k <= N; k++) begin
        checks++;
        if (ra1[k] != ((k == 0) ? N - 1 : k - 1)) begin
          errors++; $display("FAIL full_rd_addr[%0d] got=%0d exp=%0d", k, ra1[k], (k == 0) ? N - 1 : k - 1);
        end
      end
    end
    if (iss_a.size() >= 2) begin
      checks++; if (iss_a[0] !== mem[0]) begin errors++; $display("FAIL wrap_in1 got=%0h exp=%0h", iss_a[0], mem[0]); end
      checks++; if (iss_b[0] !== mem[N-1]) begin errors++; $display("FAIL wrap_in2 got=%0h exp=%0h", iss_b[0], mem[N-1]); end
      checks++; if (iss_b[1] !== mem[0]) begin errors++; $display("FAIL second_in2 got=%0h exp=%0h", iss_b[1], mem[0]); end
    end else begin
      checks++; errors++; $display("FAIL issue_count got=%0d exp=%0d", iss_a.size(), N);
    end
  endtask

  task automatic test_random_passes();
    for (int p = 0; p < 3; p++) begin
      fill_random();
      clear_mon();
      start1();
      repeat (270) @(negedge clk);
      checks++; if (wa1.size() != N) begin errors++; $display("FAIL rand%0d_wr_count got=%0d exp=%0d", p, wa1.size(), N); end
      if (wa1.size() == N) begin
        for (int z = 0; z < N; z++) begin
          checks++;
          if (wa1[z] != z || wd1[z] !== exp_word(z)) begin
            errors++; $display("FAIL rand%0d_write[%0d] got=%0d/%0h exp=%0d/%0h", p, z, wa1[z], wd1[z], z, exp_word(z));
          end
        end
      end
      checks++;
      if (dc1.size() != 1 || (dc1.size() == 1 && dc1[0] - t0 != 259)) begin
        errors++; $display("FAIL rand%0d_done got_count=%0d exp=1 at 259", p, dc1.size());
      end
    end
  endtask

  task automatic test_start_ignored();
    fill_random();
    clear_mon();
    start1();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      b1.start = ((cyc - t0) == 10 || (cyc - t0) == 200);
    end
    b1.start = 1'b0;
    checks++; if (dc1.size() != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dc1.size()); end
    if (dc1.size() >= 1) begin
      checks++; if (dc1[0] - t0 != 259) begin errors++; $display("FAIL ignore_done_cycle got=%0d exp=259", dc1[0] - t0); end
    end
    checks++; if (wa1.size() != N) begin errors++; $display("FAIL ignore_wr_count got=%0d exp=%0d", wa1.size(), N); end
    // Start held high: the pass re-triggers from IDLE right after DONE.
    clear_mon();
    @(negedge clk); b1.start = 1'b1; t0 = cyc;
    while ((cyc - t0) < 261) @(negedge clk);
    b1.start = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (dc1.size() != 2) begin errors++; $display("FAIL held_done_count got=%0d exp=2", dc1.size()); end
    if (dc1.size() == 2) begin
      checks++; if (dc1[1] - t0 != 519) begin errors++; $display("FAIL held_done2_cycle got=%0d exp=519", dc1[1] - t0); end
    end
    checks++; if (wa1.size() != 2 * N) begin errors++; $display("FAIL held_wr_count got=%0d exp=%0d", wa1.size(), 2 * N); end
    if (ra1.size() > N + 1) begin
      checks++; if (rc1[N+1] - t0 != 261) begin errors++; $display("FAIL held_rdprev_cycle got=%0d exp=261", rc1[N+1] - t0); end
      checks++; if (ra1[N+1] != N - 1) begin errors++; $display("FAIL held_rdprev_addr got=%0d exp=%0d", ra1[N+1], N - 1); end
    end else begin
      checks++; errors++; $display("FAIL held_rd_count got=%0d exp=%0d", ra1.size(), 2 * (N + 1));
    end
  endtask

  task automatic test_reset_mid_pass();
    bit found;
    found = 1'b0;
    fill_random();
    clear_mon();
    start1();
    for (int k = 0; k < 200 && !found; k++) begin
      @(posedge clk); #2;
      if (b1.wr_en === 1'b1 && b1.wr_addr == AW'(20)) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_slice20 got=0 exp=1"); end
    rst_n = 1'b0;
    #1;
    checks++; if (b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.rd_en !== 1'b0) begin
      errors++; $display("FAIL midrst_ctrl got=%0b%0b%0b exp=000", b1.busy, b1.done, b1.rd_en); end
    checks++; if (b1.unit_en !== 1'b0 || b1.wr_en !== 1'b0) begin
      errors++; $display("FAIL midrst_en got=%0b%0b exp=00", b1.unit_en, b1.wr_en); end
    checks++; if (b1.unit_in1 !== '0 || b1.unit_in2 !== '0) begin
      errors++; $display("FAIL midrst_unit_in got=%0h/%0h exp=0/0", b1.unit_in1, b1.unit_in2); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (wa1.size() != 20) begin errors++; $display("FAIL midrst_partial_writes got=%0d exp=20", wa1.size()); end
    clear_mon();
    start1();
    repeat (270) @(negedge clk);
    if (ra1.size() >= 1) begin
      checks++; if (ra1[0] != N - 1) begin errors++; $display("FAIL midrst_first_rd got=%0d exp=%0d", ra1[0], N - 1); end
    end else begin
      checks++; errors++; $display("FAIL midrst_no_reads got=0 exp=%0d", N + 1);
    end
    checks++; if (wa1.size() != N) begin errors++; $display("FAIL midrst_wr_count got=%0d exp=%0d", wa1.size(), N); end
    if (wa1.size() == N) begin
      for (int z = 0; z < N; z++) begin
        checks++;
        if (wa1[z] != z || wd1[z] !== exp_word(z)) begin
          errors++; $display("FAIL midrst_write[%0d] got=%0d/%0h exp=%0d/%0h", z, wa1[z], wd1[z], z, exp_word(z));
        end
      end
    end
  endtask

  task automatic test_lat3();
    int ue_base;
    fill_random();
    clear_mon();
    @(negedge clk); b3.start = 1'b1; t0 = cyc; ue_base = ue3_cnt;
    @(negedge clk); b3.start = 1'b0;
    repeat (420) @(negedge clk);
    checks++; if (dc3.size() != 1) begin errors++; $display("FAIL lat3_done_count got=%0d exp=1", dc3.size()); end
    if (dc3.size() >= 1) begin
      checks++; if (dc3[0] - t0 != 387) begin errors++; $display("FAIL lat3_done_cycle got=%0d exp=387", dc3[0] - t0); end
    end
    checks++; if (ue3_cnt - ue_base != 4 * N) begin errors++; $display("FAIL lat3_unit_en_cycles got=%0d exp=%0d", ue3_cnt - ue_base, 4 * N); end
    checks++; if (wa3.size() != N) begin errors++; $display("FAIL lat3_wr_count got=%0d exp=%0d", wa3.size(), N); end
    if (wa3.size() == N) begin
      checks++; if (wc3[0] - t0 != 8) begin errors++; $display("FAIL lat3_first_write got=%0d exp=8", wc3[0] - t0); end
      checks++; if (wc3[1] - wc3[0] != 6) begin errors++; $display("FAIL lat3_slice_period got=%0d exp=6", wc3[1] - wc3[0]); end
      for (int z = 0; z < N; z++) begin
        checks++;
        if (wa3[z] != z || wd3[z] !== exp_word(z)) begin
          errors++; $display("FAIL lat3_write[%0d] got=%0d/%0h exp=%0d/%0h", z, wa3[z], wd3[z], z, exp_word(z));
        end
      end
    end
  endtask

  initial begin
    b1.start = 1'b0;
    b3.start = 1'b0;
    for (int z = 0; z < N; z++) mem[z] = '0;
    test_reset();
    test_full_pass();
    test_random_passes();
    test_start_ignored();
    test_reset_mid_pass();
    test_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
